// File: rtl/symbol_serializer.sv
// Byte-to-symbol serializer feeding the Packetizer payload port: BPSK (1 bit) or
// QPSK (2 bits) symbols, MSB first, replicated across the output bus.
module symbol_serializer #(
    parameter int BYTES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_enable,
    input  logic               is_bpsk,
    input  logic [7:0]         S_tdata,
    input  logic               S_tvalid,
    output logic               S_tready,
    input  logic               S_tlast,
    output logic [BYTES*8-1:0] O_tdata,
    output logic               O_tvalid,
    input  logic               O_tready,
    output logic               O_tlast,
    output logic               O_tuser,
    output logic [15:0]        sym_count,
    output logic               pkt_done
);

    localparam int BITS = BYTES * 8;

    logic [7:0]      shreg, shreg_n;
    logic [3:0]      sym_left, sym_left_n;
    logic            last_byte, last_n;
    logic            in_pkt, in_pkt_n;
    logic [15:0]     count_n;
    logic [BITS-1:0] tdata_n;
    logic            busy, out_hs, load, tlast_hs, pkt_open, start, mode_n;

    // A byte loaded on the same edge as the previous packet's tlast symbol opens a new packet.
    always_comb begin
        busy     = (sym_left != 4'd0);
        out_hs   = clk_enable & O_tvalid & O_tready;
        S_tready = clk_enable & (~busy | (O_tready & (sym_left == 4'd1)));
        load     = S_tvalid & S_tready;
        tlast_hs = out_hs & O_tlast;
        pkt_open = in_pkt & ~tlast_hs;
        start    = load & ~pkt_open;
        mode_n   = start ? is_bpsk : O_tuser;

        shreg_n    = shreg;
        sym_left_n = sym_left;
        last_n     = last_byte;
        count_n    = sym_count;

        if (out_hs) begin
            shreg_n    = O_tuser ? {shreg[6:0], 1'b0} : {shreg[5:0], 2'b00};
            sym_left_n = sym_left - 4'd1;
            if (sym_count != 16'hFFFF)
                count_n = sym_count + 16'd1;
        end
        if (load) begin
            shreg_n    = S_tdata;
            sym_left_n = mode_n ? 4'd8 : 4'd4;
            last_n     = S_tlast;
        end
        if (start)
            count_n = 16'd0;

        in_pkt_n = pkt_open | start;
        tdata_n  = mode_n ? {BITS{shreg_n[7]}} : {BITS/2{shreg_n[7:6]}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= 8'd0;
            sym_left  <= 4'd0;
            last_byte <= 1'b0;
            in_pkt    <= 1'b0;
            O_tvalid  <= 1'b0;
            O_tdata   <= '0;
            O_tlast   <= 1'b0;
            O_tuser   <= 1'b1;
            sym_count <= 16'd0;
            pkt_done  <= 1'b0;
        end else if (clk_enable) begin
            shreg     <= shreg_n;
            sym_left  <= sym_left_n;
            last_byte <= last_n;
            in_pkt    <= in_pkt_n;
            O_tvalid  <= (sym_left_n != 4'd0);
            O_tdata   <= tdata_n;
            O_tlast   <= last_n & (sym_left_n == 4'd1);
            O_tuser   <= mode_n;
            sym_count <= count_n;
            pkt_done  <= tlast_hs;
        end
    end

endmodule

// File: tb/tb_symbol_serializer.sv
// Scoreboard bench for symbol_serializer: accepted bytes are expanded into expected
// symbols by a byte-level model; a negedge monitor pops and compares on each handshake.
module tb_symbol_serializer;

    logic        clk = 1'b0;
    logic        rst, clk_enable, is_bpsk;
    logic [7:0]  S_tdata;
    logic        S_tvalid, S_tready, S_tlast;
    logic [7:0]  O_tdata;
    logic        O_tvalid, O_tready, O_tlast, O_tuser;
    logic [15:0] sym_count;
    logic        pkt_done;

    always #5 clk = ~clk;

    symbol_serializer #(.BYTES(1)) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .is_bpsk(is_bpsk),
        .S_tdata(S_tdata), .S_tvalid(S_tvalid), .S_tready(S_tready), .S_tlast(S_tlast),
        .O_tdata(O_tdata), .O_tvalid(O_tvalid), .O_tready(O_tready), .O_tlast(O_tlast),
        .O_tuser(O_tuser), .sym_count(sym_count), .pkt_done(pkt_done)
    );

    typedef struct packed {
        logic [7:0] tdata;
        logic       tlast;
        logic       tuser;
    } sym_t;

    sym_t sbq[$];
    int   pktq[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, hs_count = 0, last_tlast_cyc = 0;
    bit   new_pkt = 1, pkt_mode = 1, rand_mode = 0;
    int   pkt_bytes = 0;
    bit   last_en = 0, expect_done = 0, expect_zero = 0;
    int   done_count = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Byte-level reference: slice the byte MSB first into 1- or 2-bit symbols for the packet's mode.
    task automatic modelByte(input logic [7:0] data, input logic last, input logic bpsk);
        int   bps, spb, sym;
        sym_t s;
        if (new_pkt) begin
            pkt_mode  = bpsk;
            pkt_bytes = 0;
            new_pkt   = 0;
        end
        pkt_bytes++;
        bps = pkt_mode ? 1 : 2;
        spb = 8 / bps;
        for (int k = 0; k < spb; k++) begin
            sym     = (int'(data) >> (8 - bps * (k + 1))) & ((1 << bps) - 1);
            s.tdata = pkt_mode ? 8'(sym * 255) : 8'(sym * 85);
            s.tlast = last && (k == spb - 1);
            s.tuser = pkt_mode;
            sbq.push_back(s);
        end
        if (last) begin
            pktq.push_back(pkt_bytes * spb);
            new_pkt = 1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic last, input logic bpsk,
                                 output int waits, output int acc_cyc);
        bit done;
        done     = 0;
        waits    = 0;
        acc_cyc  = 0;
        S_tdata  = data;
        S_tlast  = last;
        is_bpsk  = bpsk;
        S_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (!rst && clk_enable && S_tready) begin
                modelByte(data, last, bpsk);
                acc_cyc = cyc;
                done    = 1;
            end else begin
                waits++;
                if (waits > 300) begin
                    checkOutput("byte_accept_timeout", 32'(waits), 0);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0)
            checkOutput("drain_timeout", 32'(sbq.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic hs;
        sym_t s;
        if (rst) begin
            last_en     = 0;
            expect_done = 0;
        end else begin
            if (last_en) begin
                checkOutput("pkt_done", pkt_done, expect_done);
                if (expect_done)
                    checkOutput("sym_count_final", sym_count, expect_zero ? 0 : done_count);
            end
            hs          = clk_enable & O_tvalid & O_tready;
            expect_done = 0;
            if (hs) begin
                hs_count++;
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_symbol", O_tdata, 32'hFFFF_FFFF);
                end else begin
                    s = sbq.pop_front();
                    checkOutput("O_tdata", O_tdata, s.tdata);
                    checkOutput("O_tlast", O_tlast, s.tlast);
                    checkOutput("O_tuser", O_tuser, s.tuser);
                    if (s.tlast) begin
                        expect_done    = 1;
                        last_tlast_cyc = cyc;
                        done_count     = (pktq.size() > 0) ? pktq.pop_front() : -1;
                        expect_zero    = S_tvalid & S_tready;
                    end
                end
            end
            last_en = clk_enable;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            O_tready   = ($urandom_range(0, 9) < 7);
            clk_enable = ($urandom_range(0, 9) != 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired: got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w, w2, c0, c1, len;
        rst = 1; clk_enable = 1; is_bpsk = 1; O_tready = 1;
        S_tdata = 0; S_tvalid = 0; S_tlast = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checkOutput("rst_O_tvalid", O_tvalid, 0);
        checkOutput("rst_O_tlast", O_tlast, 0);
        checkOutput("rst_O_tdata", O_tdata, 0);
        checkOutput("rst_O_tuser", O_tuser, 1);
        checkOutput("rst_sym_count", sym_count, 0);
        checkOutput("rst_pkt_done", pkt_done, 0);
        checkOutput("rst_S_tready", S_tready, 1);
        @(posedge clk);
        #1;

        $display("[TB] BPSK single byte 0xA5");
        applyStimulus(8'hA5, 1, 1, w, c0);
        S_tvalid = 0;
        waitDrain();
        checkOutput("t1_tlast_latency", 32'(last_tlast_cyc - c0), 8);
        checkOutput("t1_idle_tvalid", O_tvalid, 0);

        $display("[TB] QPSK streaming 0x1B, 0xE4");
        applyStimulus(8'h1B, 0, 0, w, c0);
        applyStimulus(8'hE4, 1, 0, w2, c1);
        S_tvalid = 0;
        checkOutput("t2_first_wait", 32'(w), 0);
        checkOutput("t2_second_wait", 32'(w2), 3);
        waitDrain();
        checkOutput("t2_tlast_latency", 32'(last_tlast_cyc - c0), 8);

        $display("[TB] QPSK backpressure");
        applyStimulus(8'h1B, 1, 0, w, c0);
        S_tvalid = 0;
        @(posedge clk);
        #1 O_tready = 0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t3_hold_tdata", O_tdata, 8'h55);
            checkOutput("t3_hold_tvalid", O_tvalid, 1);
            checkOutput("t3_hold_S_tready", S_tready, 0);
            @(posedge clk);
        end
        #1 O_tready = 1;
        waitDrain();

        $display("[TB] mode latched per packet");
        applyStimulus(8'h3D, 0, 1, w, c0);
        applyStimulus(8'hC8, 0, 0, w, c0);
        applyStimulus(8'h71, 1, 0, w, c0);
        S_tvalid = 0;
        waitDrain();
        applyStimulus(8'h9E, 1, 0, w, c0);
        S_tvalid = 0;
        waitDrain();

        $display("[TB] reset mid-byte");
        applyStimulus(8'hC3, 0, 1, w, c0);
        S_tvalid = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5_rst_tvalid", O_tvalid, 0);
        checkOutput("t5_rst_sym_count", sym_count, 0);
        checkOutput("t5_rst_S_tready", S_tready, 1);
        sbq.delete();
        pktq.delete();
        new_pkt = 1;
        rst = 0;
        @(posedge clk);
        #1;
        applyStimulus(8'h80, 1, 1, w, c0);
        S_tvalid = 0;
        waitDrain();

        $display("[TB] clock enable freeze");
        applyStimulus(8'h96, 0, 1, w, c0);
        S_tvalid = 0;
        repeat (7) @(posedge clk);
        #1;
        clk_enable = 0;
        S_tdata = 8'h3C; S_tlast = 1; S_tvalid = 1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("t6_frozen_S_tready", S_tready, 0);
            checkOutput("t6_frozen_tvalid", O_tvalid, 1);
            checkOutput("t6_frozen_tdata", O_tdata, sbq[0].tdata);
            checkOutput("t6_frozen_tlast", O_tlast, sbq[0].tlast);
            checkOutput("t6_frozen_sym_count", sym_count, 7);
            @(posedge clk);
        end
        #1 clk_enable = 1;
        applyStimulus(8'h3C, 1, 1, w, c0);
        S_tvalid = 0;
        checkOutput("t6_resume_wait", 32'(w), 0);
        waitDrain();

        $display("[TB] randomized packets");
        rand_mode = 1;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                applyStimulus(8'($urandom), (b == len - 1), 1'($urandom_range(0, 1)), w, c0);
                if ($urandom_range(0, 3) == 0) begin
                    S_tvalid = 0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        end
        S_tvalid = 0;
        rand_mode = 0;
        @(posedge clk);
        #2;
        O_tready = 1;
        clk_enable = 1;
        waitDrain();
        checkOutput("pktq_empty", 32'(pktq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
